// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: collects one SIZE x SIZE operand pair (A as columns,
// B as rows), resets the systolic array for one cycle, then replays the pair
// as diagonally skewed wavefronts and drains zeros until the array reports done.
module systolic_skew_feeder #(
    parameter int SIZE       = 8,
    parameter int DATA_WIDTH = 8,
    parameter int DRAIN_MAX  = 64
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SIZE*DATA_WIDTH-1:0]   in_a_col,
    input  logic [SIZE*DATA_WIDTH-1:0]   in_b_row,
    output logic                         sa_rst,
    output logic [SIZE*DATA_WIDTH-1:0]   sa_a,
    output logic [SIZE*DATA_WIDTH-1:0]   sa_b,
    input  logic                         sa_done,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         timeout,
    output logic [1:0]                   dbg_state
);

    localparam int VW      = SIZE * DATA_WIDTH;
    localparam int BEAT_W  = $clog2(SIZE) + 1;
    localparam int SLICE_W = $clog2(2 * SIZE) + 1;
    localparam int DRAIN_W = $clog2(DRAIN_MAX) + 1;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_CLR    = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [SLICE_W-1:0]   slice_q, slice_d;
    logic [DRAIN_W-1:0]   drain_q, drain_d;
    logic [VW-1:0]        sa_a_q, sa_a_d;
    logic [VW-1:0]        sa_b_q, sa_b_d;
    logic                 sa_rst_q, sa_rst_d;
    logic                 frame_done_q, frame_done_d;
    logic                 timeout_q, timeout_d;

    // a_col_q[k] holds column k of A, b_row_q[k] holds row k of B.
    logic [VW-1:0]        a_col_q [SIZE];
    logic [VW-1:0]        a_col_d [SIZE];
    logic [VW-1:0]        b_row_q [SIZE];
    logic [VW-1:0]        b_row_d [SIZE];

    logic [VW-1:0]        slice_a;
    logic [VW-1:0]        slice_b;
    int                   slice_t;
    logic                 accept;

    // Handshake: a beat transfers on a rising edge where in_valid and in_ready
    // are both high; in_ready depends only on state and reset, never on in_valid,
    // and data on the inputs is ignored whenever in_ready is low.
    assign in_ready = rst && (state_q == ST_LOAD);
    assign accept   = in_valid && in_ready;

    // Skewed slice t: lane i of A takes A[i][t-i], lane j of B takes B[t-j][j].
    // In CLR the slice index is forced to 0 so slice 0 is ready for the entry edge.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        slice_t = (state_q == ST_STREAM) ? int'(slice_q) : 0;
        for (int i = 0; i < SIZE; i++) begin
            for (int k = 0; k < SIZE; k++) begin
                if (slice_t == i + k) begin
                    slice_a[i*DATA_WIDTH +: DATA_WIDTH] = a_col_q[k][i*DATA_WIDTH +: DATA_WIDTH];
                    slice_b[i*DATA_WIDTH +: DATA_WIDTH] = b_row_q[k][i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    // Operand buffer capture: accepted beat k lands in column/row slot k.
    always_comb begin
        for (int k = 0; k < SIZE; k++) begin
            a_col_d[k] = a_col_q[k];
            b_row_d[k] = b_row_q[k];
            if (accept && (beat_q == BEAT_W'(k))) begin
                a_col_d[k] = in_a_col;
                b_row_d[k] = in_b_row;
            end
        end
    end

    // Operand buffer storage; contents are meaningless until a frame is loaded.
    always_ff @(posedge clk) begin
        for (int k = 0; k < SIZE; k++) begin
            a_col_q[k] <= a_col_d[k];
            b_row_q[k] <= b_row_d[k];
        end
    end

    // Next-state logic: frame sequencing, counters and registered outputs.
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        slice_d      = slice_q;
        drain_d      = drain_q;
        sa_a_d       = '0;
        sa_b_d       = '0;
        frame_done_d = 1'b0;
        timeout_d    = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (beat_q == BEAT_W'(SIZE - 1)) begin
                        beat_d  = '0;
                        state_d = ST_CLR;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
            end
            ST_CLR: begin
                // Slice 0 goes out on the same edge that releases the array reset.
                state_d = ST_STREAM;
                sa_a_d  = slice_a;
                sa_b_d  = slice_b;
                slice_d = SLICE_W'(1);
            end
            ST_STREAM: begin
                if (slice_q == SLICE_W'(2 * SIZE - 1)) begin
                    state_d = ST_DRAIN;
                    slice_d = '0;
                    drain_d = '0;
                end else begin
                    sa_a_d  = slice_a;
                    sa_b_d  = slice_b;
                    slice_d = slice_q + SLICE_W'(1);
                end
            end
            ST_DRAIN: begin
                // sa_done is checked first so it wins over a coinciding expiry.
                if (sa_done) begin
                    frame_done_d = 1'b1;
                    state_d      = ST_LOAD;
                    drain_d      = '0;
                end else if (drain_q == DRAIN_W'(DRAIN_MAX - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_LOAD;
                    drain_d   = '0;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
        sa_rst_d = (state_d != ST_CLR);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_LOAD;
            beat_q       <= '0;
            slice_q      <= '0;
            drain_q      <= '0;
            sa_a_q       <= '0;
            sa_b_q       <= '0;
            sa_rst_q     <= 1'b0;
            frame_done_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_q       <= beat_d;
            slice_q      <= slice_d;
            drain_q      <= drain_d;
            sa_a_q       <= sa_a_d;
            sa_b_q       <= sa_b_d;
            sa_rst_q     <= sa_rst_d;
            frame_done_q <= frame_done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign sa_a       = sa_a_q;
    assign sa_b       = sa_b_q;
    assign sa_rst     = sa_rst_q;
    assign frame_done = frame_done_q;
    assign timeout    = timeout_q;
    assign busy       = (state_q != ST_LOAD);
    assign dbg_state  = state_q;

endmodule
